// File: rtl/dpram_label_fetch_pkg.sv
// Shared definitions for the garbled-label fetch client.
//  - fetch_state_t : transaction states IDLE -> WAIT -> HOLD -> IDLE
//  - STAT_W        : width of the optional statistics counters
//  - *_DEF         : default address / label / tag widths (module parameters
//                    S, K and G take these as defaults)
//  - sat_inc       : saturating increment used by the stall counter
package dpram_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  localparam int STAT_W      = 32;
  localparam int ADDR_W_DEF  = 20;
  localparam int LABEL_W_DEF = 128;
  localparam int TAG_W_DEF   = 16;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/dpram_label_fetch_if.sv
// Bus bundle between scheduler, label RAM, fetcher and evaluator.
//  Request side : req_valid/req_ready handshake, req_addr_a/b, req_single, req_tag
//  RAM side     : rd_addr_0/1 out of the fetcher, rd_data_ready_0/1 and
//                 rd_data_0/1 back from the RAM (combinational)
//  Output side  : out_valid/out_ready handshake, out_label_a/b, out_tag
// Modports: slave = the fetcher, master = everything around it.
interface dpram_label_fetch_if #(
  parameter int S = dpram_fetch_pkg::ADDR_W_DEF,
  parameter int K = dpram_fetch_pkg::LABEL_W_DEF,
  parameter int G = dpram_fetch_pkg::TAG_W_DEF
);
  logic         req_valid;
  logic         req_ready;
  logic [S-1:0] req_addr_a;
  logic [S-1:0] req_addr_b;
  logic         req_single;
  logic [G-1:0] req_tag;

  logic [S-1:0] rd_addr_0;
  logic [S-1:0] rd_addr_1;
  logic         rd_data_ready_0;
  logic         rd_data_ready_1;
  logic [K-1:0] rd_data_0;
  logic [K-1:0] rd_data_1;

  logic         out_valid;
  logic         out_ready;
  logic [K-1:0] out_label_a;
  logic [K-1:0] out_label_b;
  logic [G-1:0] out_tag;

  modport slave (
    input  req_valid, req_addr_a, req_addr_b, req_single, req_tag,
    output req_ready,
    output rd_addr_0, rd_addr_1,
    input  rd_data_ready_0, rd_data_ready_1, rd_data_0, rd_data_1,
    output out_valid, out_label_a, out_label_b, out_tag,
    input  out_ready
  );

  modport master (
    output req_valid, req_addr_a, req_addr_b, req_single, req_tag,
    input  req_ready,
    input  rd_addr_0, rd_addr_1,
    output rd_data_ready_0, rd_data_ready_1, rd_data_0, rd_data_1,
    input  out_valid, out_label_a, out_label_b, out_tag,
    output out_ready
  );

endinterface

// File: rtl/dpram_label_fetch_stats_cnt.sv
// Statistics counters for the label fetcher.
//  clk, rst_n (async, active-low), clr (sync) : clocking / clearing
//  stall_inc  : one cycle spent waiting for label flags
//  fetch_inc  : one completed output handshake
//  stat_stall : saturating count of stall cycles
//  stat_fetch : wrapping count of completed fetches
module fetch_stats_cnt import dpram_fetch_pkg::*; (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              stall_inc,
  input  logic              fetch_inc,
  output logic [STAT_W-1:0] stat_stall,
  output logic [STAT_W-1:0] stat_fetch
);

  logic [STAT_W-1:0] stall_reg;
  logic [STAT_W-1:0] fetch_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_reg <= '0;
      fetch_reg <= '0;
    end else if (clr) begin
      stall_reg <= '0;
      fetch_reg <= '0;
    end else begin
      if (stall_inc) stall_reg <= sat_inc(stall_reg);
      if (fetch_inc) fetch_reg <= fetch_reg + STAT_W'(1);
    end
  end

  assign stat_stall = stall_reg;
  assign stat_fetch = fetch_reg;

endmodule

// File: rtl/dpram_label_fetch.sv
// Read-side client of the garbled-label dual-port RAM.
// Accepts a gate request (two wire addresses + tag), points both RAM read
// ports at the registered addresses, waits for each label's written flag,
// captures the labels and hands the pair to the evaluator.
// Ports:
//  clk, rst_n (async, active-low), clr (sync abort, same effect as reset)
//  bus        : dpram_label_fetch_if.slave (request, RAM read, output handshakes)
//  stat_stall : cycles spent in WAIT without both labels (saturating)
//  stat_fetch : completed output handshakes (wrapping)
//               -- both stat ports exist only when FETCH_STATS_EN is defined.
module dpram_label_fetch import dpram_fetch_pkg::*; #(
  parameter int S = ADDR_W_DEF,
  parameter int K = LABEL_W_DEF,
  parameter int G = TAG_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  dpram_label_fetch_if.slave bus
`ifdef FETCH_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_stall,
  output logic [STAT_W-1:0] stat_fetch
`endif
);

  fetch_state_t state_reg, state_next;
  logic [S-1:0] addr_a_reg, addr_a_next;
  logic [S-1:0] addr_b_reg, addr_b_next;
  logic [G-1:0] tag_reg, tag_next;
  logic [1:0]   got_reg, got_next;
  logic [K-1:0] label_reg  [2];
  logic [K-1:0] label_next [2];

  // Per-port view of the RAM: index 0 = wire A, index 1 = wire B.
  logic [1:0]   flag_in;
  logic [K-1:0] data_in [2];
  logic [1:0]   capture;

  assign flag_in    = {bus.rd_data_ready_1, bus.rd_data_ready_0};
  assign data_in[0] = bus.rd_data_0;
  assign data_in[1] = bus.rd_data_1;

  // A port captures once: the first cycle its flag is seen while not yet got.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cap
      assign capture[gi] = (state_reg == WAIT) && !got_reg[gi] && flag_in[gi];
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    addr_a_next   = addr_a_reg;
    addr_b_next   = addr_b_reg;
    tag_next      = tag_reg;
    got_next      = got_reg;
    label_next[0] = label_reg[0];
    label_next[1] = label_reg[1];

    case (state_reg)
      IDLE: begin
        if (bus.req_valid) begin
          addr_a_next   = bus.req_addr_a;
          addr_b_next   = bus.req_addr_b;
          tag_next      = bus.req_tag;
          // A unary gate never needs port 1, so B counts as already got and
          // its label stays zero.
          got_next      = {bus.req_single, 1'b0};
          label_next[0] = '0;
          label_next[1] = '0;
          state_next    = WAIT;
        end
      end
      WAIT: begin
        for (int i = 0; i < 2; i++) begin
          if (capture[i]) begin
            got_next[i]   = 1'b1;
            label_next[i] = data_in[i];
          end
        end
        if (&got_next) state_next = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          got_next   = '0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Abort wins over any handshake in the same cycle.
    if (clr) begin
      state_next    = IDLE;
      addr_a_next   = '0;
      addr_b_next   = '0;
      tag_next      = '0;
      got_next      = '0;
      label_next[0] = '0;
      label_next[1] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      addr_a_reg <= '0;
      addr_b_reg <= '0;
      tag_reg    <= '0;
      got_reg    <= '0;
      for (int i = 0; i < 2; i++) label_reg[i] <= '0;
    end else begin
      state_reg  <= state_next;
      addr_a_reg <= addr_a_next;
      addr_b_reg <= addr_b_next;
      tag_reg    <= tag_next;
      got_reg    <= got_next;
      for (int i = 0; i < 2; i++) label_reg[i] <= label_next[i];
    end
  end

  // RAM addresses come only from registers, never straight from req_*.
  assign bus.rd_addr_0   = addr_a_reg;
  assign bus.rd_addr_1   = addr_b_reg;
  assign bus.req_ready   = (state_reg == IDLE);
  assign bus.out_valid   = (state_reg == HOLD);
  assign bus.out_label_a = label_reg[0];
  assign bus.out_label_b = label_reg[1];
  assign bus.out_tag     = tag_reg;

`ifdef FETCH_STATS_EN
  logic stall_inc;
  logic fetch_inc;

  assign stall_inc = (state_reg == WAIT) && !(&got_reg);
  assign fetch_inc = bus.out_valid && bus.out_ready && !clr;

  fetch_stats_cnt u_stats (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .stall_inc  (stall_inc),
    .fetch_inc  (fetch_inc),
    .stat_stall (stat_stall),
    .stat_fetch (stat_fetch)
  );
`endif

endmodule
